// File: rtl/lenet_pkg.sv
// Shared LeNet constants and the fully-connected loader state encoding.
package lenet_pkg;

    localparam int FC84_N = 84;
    localparam int ACT_W  = 64;
    localparam int WGT_W  = 32;
    localparam int SUM_W  = 64;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } fc_load_state_t;

endpackage

// File: rtl/fc_84_loader_if.sv
// Activation/weight input stream plus the result handshake of the FC-84 loader.
// master drives pairs and res_ready; slave is the loader.
interface fc_84_loader_if;

    logic                       s_valid;
    logic                       s_ready;
    logic [lenet_pkg::ACT_W-1:0] s_data;
    logic [lenet_pkg::WGT_W-1:0] s_weight;
    logic                       s_last;

    logic                       res_valid;
    logic                       res_ready;
    logic [lenet_pkg::SUM_W-1:0] res_data;

    modport master (
        output s_valid, s_data, s_weight, s_last, res_ready,
        input  s_ready, res_valid, res_data
    );

    modport slave (
        input  s_valid, s_data, s_weight, s_last, res_ready,
        output s_ready, res_valid, res_data
    );

endinterface

// File: rtl/fc_slot_bank.sv
// N-entry activation/weight register file: indexed write, clear-all, flattened read-out.
// Write lands on the next edge; no backpressure, the owner decides when to write.
module fc_slot_bank #(
    parameter int N  = 84,
    parameter int AW = 64,
    parameter int WW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            we,
    input  logic [6:0]      widx,
    input  logic [AW-1:0]   wdat,
    input  logic [WW-1:0]   wwgt,
    output logic [AW*N-1:0] vec_out,
    output logic [WW*N-1:0] w_out
);

    logic [AW-1:0] act_q [N];
    logic [WW-1:0] wgt_q [N];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < N; i++) begin
                act_q[i] <= '0;
                wgt_q[i] <= '0;
            end
        end else if (we && (widx < 7'(N))) begin
            act_q[widx] <= wdat;
            wgt_q[widx] <= wwgt;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign vec_out[g*AW +: AW] = act_q[g];
        assign w_out[g*WW +: WW]   = wgt_q[g];
    end

endmodule

// File: rtl/fc_84_loader.sv
// Serial-to-parallel loader for the 84-input FC neuron; result valid 2 cycles after the last accept.
// s_ready drops from vector end until one cycle after the result handshake; result held until res_ready.
module fc_84_loader
    import lenet_pkg::*;
#(
    parameter int N         = FC84_N,
    parameter int IN_WIDTH  = ACT_W,
    parameter int BIT_WIDTH = WGT_W,
    parameter int OUT_WIDTH = SUM_W
) (
    input  logic                   clk,
    input  logic                   reset,
    fc_84_loader_if.slave          io,
    input  logic [BIT_WIDTH-1:0]   bias_in,
    input  logic                   bias_load,
    output logic [IN_WIDTH*N-1:0]  vec_out,
    output logic [BIT_WIDTH*N-1:0] w_out,
    output logic [BIT_WIDTH-1:0]   bias_out,
    input  logic [OUT_WIDTH-1:0]   fc_sum,
    output logic                   len_err
);

    localparam logic [6:0] LAST_IDX = 7'(N - 1);

    fc_load_state_t         state_q, state_d;
    logic [6:0]             idx_q, idx_d;
    logic                   accept;
    logic                   at_last;
    logic                   clr;
    logic                   len_err_d;
    logic                   res_valid_q;
    logic [OUT_WIDTH-1:0]   res_data_q;
    logic [BIT_WIDTH-1:0]   bias_q;

    assign io.s_ready  = (state_q == FILL) && !reset;
    assign accept      = io.s_valid && io.s_ready;
    assign at_last     = (idx_q == LAST_IDX);
    assign io.res_valid = res_valid_q;
    assign io.res_data  = res_data_q;
    assign bias_out     = bias_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clr       = 1'b0;
        len_err_d = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    // s_last early (zero-padded vector) or missing at the final slot (overrun)
                    len_err_d = io.s_last ^ at_last;
                    if (io.s_last || at_last) begin
                        state_d = EVAL;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            EVAL: state_d = DONE;
            DONE: begin
                if (io.res_ready) begin
                    state_d = FILL;
                    clr     = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            idx_q       <= '0;
            len_err     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            bias_q      <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_err <= len_err_d;
            // bias is frozen while the neuron sum is being captured
            if (bias_load && (state_q != EVAL)) begin
                bias_q <= bias_in;
            end
            if (state_q == EVAL) begin
                res_data_q  <= fc_sum;
                res_valid_q <= 1'b1;
            end else if (clr) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    fc_slot_bank #(
        .N  (N),
        .AW (IN_WIDTH),
        .WW (BIT_WIDTH)
    ) u_slots (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .we      (accept),
        .widx    (idx_q),
        .wdat    (io.s_data),
        .wwgt    (io.s_weight),
        .vec_out (vec_out),
        .w_out   (w_out)
    );

endmodule

// File: tb/tb_fc_84_loader.sv
// Directed + randomized bench for fc_84_loader with a queue-based vector model and a behavioural neuron.
module tb_fc_84_loader;
    import lenet_pkg::*;

    localparam int N = FC84_N;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fc_84_loader_if io();

    logic [WGT_W-1:0]   bias_in;
    logic               bias_load;
    logic [ACT_W*N-1:0] vec_out;
    logic [WGT_W*N-1:0] w_out;
    logic [WGT_W-1:0]   bias_out;
    logic [SUM_W-1:0]   fc_sum;
    logic               len_err;

    fc_84_loader dut (
        .clk       (clk),
        .reset     (reset),
        .io        (io),
        .bias_in   (bias_in),
        .bias_load (bias_load),
        .vec_out   (vec_out),
        .w_out     (w_out),
        .bias_out  (bias_out),
        .fc_sum    (fc_sum),
        .len_err   (len_err)
    );

    // Behavioural neuron: bias plus dot product of the presented buses.
    always_comb begin
        longint acc;
        acc = longint'($signed(bias_out));
        for (int i = 0; i < N; i++) begin
            acc = acc + $signed(vec_out[i*ACT_W +: ACT_W]) * longint'($signed(w_out[i*WGT_W +: WGT_W]));
        end
        fc_sum = acc;
    end

    int             checks = 0;
    int             errors = 0;
    longint         va[$];
    logic [31:0]    wa[$];
    logic [31:0]    model_bias;
    logic [63:0]    exp_sum;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_buses(input string tag);
        logic [ACT_W*N-1:0] ev;
        logic [WGT_W*N-1:0] ew;
        int bad;
        ev  = '0;
        ew  = '0;
        bad = 0;
        foreach (va[i]) begin
            ev[i*ACT_W +: ACT_W] = va[i];
            ew[i*WGT_W +: WGT_W] = wa[i];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_out[i*ACT_W +: ACT_W] !== ev[i*ACT_W +: ACT_W] ||
                w_out[i*WGT_W +: WGT_W] !== ew[i*WGT_W +: WGT_W]) bad = i;
        end
        checks++;
        assert (vec_out === ev && w_out === ew) else begin
            errors++;
            $error("FAIL %s slot %0d: got act %h wgt %h want act %h wgt %h", tag, bad,
                   vec_out[bad*ACT_W +: ACT_W], w_out[bad*WGT_W +: WGT_W],
                   ev[bad*ACT_W +: ACT_W], ew[bad*WGT_W +: WGT_W]);
        end
    endtask

    function automatic logic [63:0] model_sum();
        longint acc;
        acc = longint'($signed(model_bias));
        foreach (va[i]) acc = acc + va[i] * longint'($signed(wa[i]));
        return acc;
    endfunction

    task automatic send(input longint d, input logic [31:0] w, input bit last, input bit exp_err);
        int n;
        n = 0;
        io.s_valid  = 1'b1;
        io.s_data   = d;
        io.s_weight = w;
        io.s_last   = last;
        while (!io.s_ready && n < 100) begin
            cycle();
            n++;
        end
        if (!io.s_ready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: s_ready still %b after %0d cycles", io.s_ready, n);
        end
        cycle();
        io.s_valid = 1'b0;
        io.s_last  = 1'b0;
        check("len_err_at_accept", 64'(len_err), 64'(exp_err));
    endtask

    // Sends va/wa back to back; an early s_last or a full vector without s_last must flag len_err.
    task automatic send_vector(input bit use_last);
        int n;
        bit err;
        n = va.size();
        for (int i = 0; i < n; i++) begin
            err = (i == n - 1) && ((use_last && n < N) || (!use_last && n == N));
            send(va[i], wa[i], use_last && (i == n - 1), err);
        end
    endtask

    task automatic fill_random(input int n);
        va.delete();
        wa.delete();
        for (int i = 0; i < n; i++) begin
            va.push_back(longint'({$urandom, $urandom}));
            wa.push_back($urandom);
        end
    endtask

    // Entered in the EVAL cycle, i.e. one cycle after the last accept.
    task automatic collect(input int stall, input bit bias_test);
        exp_sum = model_sum();
        check("eval_res_valid", 64'(io.res_valid), 64'd0);
        check("eval_s_ready", 64'(io.s_ready), 64'd0);
        io.s_valid   = 1'b1;
        io.s_data    = {$urandom, $urandom};
        io.s_weight  = $urandom;
        io.res_ready = 1'b0;
        if (bias_test) begin
            bias_in   = 32'h0001_0000;
            bias_load = 1'b1;
        end
        cycle();
        bias_load = 1'b0;
        check("res_valid_latency", 64'(io.res_valid), 64'd1);
        check("res_data", io.res_data, exp_sum);
        check("len_err_single", 64'(len_err), 64'd0);
        if (bias_test) check("bias_eval_ignored", 64'(bias_out), 64'(model_bias));
        for (int k = 0; k < stall; k++) begin
            if (bias_test && k == 0) begin
                bias_in   = 32'h0001_0000;
                bias_load = 1'b1;
            end
            cycle();
            bias_load = 1'b0;
            if (bias_test && k == 0) begin
                model_bias = 32'h0001_0000;
                check("bias_done_load", 64'(bias_out), 64'(model_bias));
            end
            check("hold_res_data", io.res_data, exp_sum);
            check("hold_res_valid", 64'(io.res_valid), 64'd1);
            check("hold_s_ready", 64'(io.s_ready), 64'd0);
        end
        io.res_ready = 1'b1;
        cycle();
        io.res_ready = 1'b0;
        check("post_hs_res_valid", 64'(io.res_valid), 64'd0);
        check("post_hs_s_ready", 64'(io.s_ready), 64'd1);
        check("post_hs_bias", 64'(bias_out), 64'(model_bias));
        io.s_valid = 1'b0;
        va.delete();
        wa.delete();
        check_buses("post_hs_cleared");
    endtask

    task automatic check_reset_state(input string tag);
        va.delete();
        wa.delete();
        check_buses(tag);
        check({tag, "_bias"}, 64'(bias_out), 64'd0);
        check({tag, "_res_valid"}, 64'(io.res_valid), 64'd0);
        check({tag, "_res_data"}, io.res_data, 64'd0);
        check({tag, "_len_err"}, 64'(len_err), 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        io.s_valid   = 1'b0;
        io.s_data    = '0;
        io.s_weight  = '0;
        io.s_last    = 1'b0;
        io.res_ready = 1'b0;
        bias_in      = '0;
        bias_load    = 1'b0;
        model_bias   = '0;
        #1;
        check("reset_s_ready", 64'(io.s_ready), 64'd0);
        cycle();
        cycle();
        check("reset_s_ready_held", 64'(io.s_ready), 64'd0);
        check_reset_state("reset");
        reset = 1'b0;
        #1;
        check("out_of_reset_s_ready", 64'(io.s_ready), 64'd1);

        // Full vector, s_data = i+1, weight 1
        va.delete();
        wa.delete();
        for (int i = 0; i < N; i++) begin
            va.push_back(longint'(i + 1));
            wa.push_back(32'd1);
        end
        send_vector(1'b1);
        check("slot83_act", vec_out[83*ACT_W +: ACT_W], 64'd84);
        check_buses("full_vec");
        collect(0, 1'b0);

        // Random bias in FILL, then same vector with backpressure and bias timing
        bias_in   = $urandom | 32'h8000_0000;
        bias_load = 1'b1;
        cycle();
        bias_load  = 1'b0;
        model_bias = bias_in;
        check("bias_fill_load", 64'(bias_out), 64'(model_bias));
        for (int i = 0; i < N; i++) begin
            va.push_back(longint'(i + 1));
            wa.push_back(32'd1);
        end
        send_vector(1'b1);
        check_buses("bp_vec");
        collect(10, 1'b1);

        // Short vector: zero padding and a single len_err pulse
        for (int i = 0; i < 5; i++) begin
            va.push_back(64'd7);
            wa.push_back(32'd2);
        end
        send_vector(1'b1);
        check_buses("short_vec");
        collect(0, 1'b0);

        // Overrun: 84 pairs without s_last, next pair starts at slot 0
        fill_random(N);
        send_vector(1'b0);
        check_buses("overrun_vec");
        collect(2, 1'b0);
        fill_random(3);
        send(va[0], wa[0], 1'b0, 1'b0);
        check("next_vec_slot0", vec_out[ACT_W-1:0], va[0]);
        send(va[1], wa[1], 1'b0, 1'b0);
        send(va[2], wa[2], 1'b1, 1'b1);
        check_buses("after_overrun_vec");
        collect(1, 1'b0);

        // Reset mid-fill discards the partial vector
        fill_random(40);
        send_vector(1'b0);
        reset = 1'b1;
        #1;
        check("midfill_reset_s_ready", 64'(io.s_ready), 64'd0);
        cycle();
        reset      = 1'b0;
        model_bias = '0;
        check_reset_state("midfill_reset");
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("aborted_no_result", 64'(io.res_valid), 64'd0);
        end
        fill_random(N);
        send(va[0], wa[0], 1'b0, 1'b0);
        check("refill_slot0", vec_out[ACT_W-1:0], va[0]);
        for (int i = 1; i < N; i++) send(va[i], wa[i], i == N - 1, 1'b0);
        check_buses("refill_vec");
        collect(1, 1'b0);

        // Random-length vectors with random stalls
        for (int r = 0; r < 4; r++) begin
            fill_random(int'($urandom_range(1, N)));
            send_vector(1'b1);
            check_buses("rand_vec");
            collect(int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
